mitchell_log_encoder: RTL and testbench
=======================================

MITCHELL_LOG_ENCODER -- requirements
Module: mitchell_log_encoder

Interface
REQ-001 Parameter A_BW, default 32: width of operand A.
REQ-002 Parameter B_BW, default 32: width of operand B.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair A/B present.
REQ-006 in_ready  output  1  encoder accepts the pair this cycle.
REQ-007 A  input  A_BW  unsigned operand A.
REQ-008 B  input  B_BW  unsigned operand B.
REQ-009 out_valid  output  1  encoded pair present.
REQ-010 out_ready  input  1  downstream multiplier consumes the pair this cycle.
REQ-011 k_1  output  $clog2(A_BW)  leading-one position of A.
REQ-012 k_2  output  $clog2(B_BW)  leading-one position of B.
REQ-013 x_1  output  A_BW  left-aligned fraction of A, leading one removed.
REQ-014 x_2  output  B_BW  left-aligned fraction of B, leading one removed.
REQ-015 A_zero_flag, B_zero_flag  output  1 each  operand equals zero.

Function
REQ-016 Transfer occurs on a cycle where valid and ready are both high, on either port.
REQ-017 Two-stage elastic pipeline:
  - S1 registers operands, k values and zero flags.
  - S2 registers x values, k values and zero flags, and drives the outputs.
REQ-018 Latency is 2 cycles from input transfer to out_valid when there is no backpressure; throughput is 1 pair/cycle.
REQ-019 k = index of the most significant set bit, computed combinationally ahead of S1.
REQ-020 x = operand << (BW - k), truncated to BW bits, computed between S1 and S2.
REQ-021 Operand zero: k=0, x=0, zero_flag=1.
REQ-022 Operand one: k=0, x=0, zero_flag=0.
REQ-023 Stage handshake:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid || s2 loads.
  - in_ready has no combinational dependency on in_valid.
REQ-024 While out_valid=1 and out_ready=0, all outputs hold stable.
REQ-025 Simultaneous input and output transfers in a full pipeline proceed with no bubble and no loss.
REQ-026 Pairs emerge in acceptance order; none is dropped or duplicated.

Reset
REQ-027 When rst=1 at a clock edge, both stage valid bits clear to 0, and out_valid, k_1, k_2, x_1, x_2, A_zero_flag and B_zero_flag become 0.
REQ-028 While rst=1, in_ready=0.
REQ-029 In-flight pairs are discarded when reset is asserted mid-operation.
REQ-030 in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-031 Shared package mitchell_pkg holds:
  - default widths A_BW and B_BW;
  - width helper constants for k;
  - the encoded-operand typedef (k, x, zero_flag).
REQ-032 Sub-module mitchell_lod_pe (leading-one detector plus priority encoder, outputs k and zero flag) is instantiated once for A and once for B.
REQ-033 The outputs connect directly to the same-named inputs of the Mitchell multiplication unit.

Verification
REQ-034 A=12, B=0xFFFFFFFF, out_ready=1 -> two cycles later: k_1=3, x_1=0x80000000, k_2=31, x_2=0xFFFFFFFE, both flags 0.
REQ-035 A=0, B=1 -> k_1=0, x_1=0, A_zero_flag=1; k_2=0, x_2=0, B_zero_flag=0.
REQ-036 A=0x80000000, B=0x00010000 -> k_1=31, x_1=0, k_2=16, x_2=0.
REQ-037 Backpressure:
  - Stimulus: send 4 back-to-back pairs with out_ready=0 for 5 cycles.
  - Response: in_ready drops after 2 pairs are accepted; outputs are held stable; on release, all 4 pairs emerge in order.
REQ-038 Reset mid-stream:
  - Stimulus: assert rst with 2 pairs in flight.
  - Response: out_valid=0 next cycle; no stale pair appears after release.
REQ-039 Random streams with random out_ready, checked against a reference model:
  - Scoreboard: every pair matches.
  - Product check: feeding the outputs into the multiplication unit gives the expected Mitchell products.

Source files
------------

// File: rtl/mitchell_pkg.sv
// Shared definitions for the Mitchell logarithmic encoder.
//   A_BW, B_BW   default operand widths
//   k_width()    width of a leading-one index for a given operand width
//   K_A_W/K_B_W  index widths at the default operand widths
//   enc_a_t/enc_b_t  encoded operand: leading-one index, left-aligned
//                    fraction with the leading one removed, zero flag
package mitchell_pkg;

    localparam int A_BW = 32;
    localparam int B_BW = 32;

    // Guard against a zero-width index for 1-bit operands.
    function automatic int k_width(input int bw);
        return (bw > 1) ? $clog2(bw) : 1;
    endfunction

    localparam int K_A_W = k_width(A_BW);
    localparam int K_B_W = k_width(B_BW);

    typedef struct packed {
        logic [K_A_W-1:0] k;
        logic [A_BW-1:0]  x;
        logic             zero_flag;
    } enc_a_t;

    typedef struct packed {
        logic [K_B_W-1:0] k;
        logic [B_BW-1:0]  x;
        logic             zero_flag;
    } enc_b_t;

endpackage

// File: rtl/mitchell_log_encoder_if.sv
// Handshake bundle between an operand source, the log encoder and the
// downstream Mitchell multiplication unit.
//   in_valid/in_ready/A/B         operand pair channel
//   out_valid/out_ready           encoded pair channel
//   k_1/k_2, x_1/x_2              leading-one index and fraction per operand
//   A_zero_flag/B_zero_flag       operand was zero
// Modports: slave = encoder view, master = environment view.
interface mitchell_log_encoder_if #(
    parameter int A_BW = mitchell_pkg::A_BW,
    parameter int B_BW = mitchell_pkg::B_BW
);
    import mitchell_pkg::*;

    localparam int KA_W = k_width(A_BW);
    localparam int KB_W = k_width(B_BW);

    logic            in_valid;
    logic            in_ready;
    logic [A_BW-1:0] A;
    logic [B_BW-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [KA_W-1:0] k_1;
    logic [KB_W-1:0] k_2;
    logic [A_BW-1:0] x_1;
    logic [B_BW-1:0] x_2;
    logic            A_zero_flag;
    logic            B_zero_flag;

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, k_1, k_2, x_1, x_2, A_zero_flag, B_zero_flag
    );

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, k_1, k_2, x_1, x_2, A_zero_flag, B_zero_flag
    );

endinterface

// File: rtl/mitchell_lod_pe.sv
// Leading-one detector plus priority encoder (purely combinational).
//   operand    value to examine
//   k          index of the most significant set bit (0 when operand <= 1)
//   zero_flag  operand is all zeros
module mitchell_lod_pe
    import mitchell_pkg::*;
#(
    parameter int BW = 32,
    parameter int KW = k_width(BW)
) (
    input  logic [BW-1:0] operand,
    output logic [KW-1:0] k,
    output logic          zero_flag
);

    // One-hot marker of the leading one: a bit qualifies only when every
    // bit above it is clear.
    logic [BW-1:0] lead;

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_lead
            if (gi == BW - 1) begin : g_top
                assign lead[gi] = operand[gi];
            end else begin : g_rest
                assign lead[gi] = operand[gi] & ~(|operand[BW-1:gi+1]);
            end
        end
    endgenerate

    // lead is one-hot (or zero), so OR-ing the indices is a clean encode.
    always_comb begin
        k = '0;
        for (int i = 0; i < BW; i++) begin
            if (lead[i]) begin
                k = k | i[KW-1:0];
            end
        end
    end

    assign zero_flag = ~|operand;

endmodule

// File: rtl/mitchell_log_encoder.sv
// Mitchell logarithmic encoder: converts an operand pair into
// (leading-one index, left-aligned fraction, zero flag) per operand for
// the Mitchell multiplication unit. Two-stage elastic pipeline:
//   S1 holds operands, indices and zero flags;
//   S2 holds fractions, indices and zero flags and drives the outputs.
// Ports:
//   clk  single clock
//   rst  synchronous active-high reset
//   bus  mitchell_log_encoder_if.slave (operand in / encoded pair out)
module mitchell_log_encoder
    import mitchell_pkg::*;
#(
    parameter int A_BW = mitchell_pkg::A_BW,
    parameter int B_BW = mitchell_pkg::B_BW
) (
    input  logic                        clk,
    input  logic                        rst,
    mitchell_log_encoder_if.slave       bus
);

    localparam int KA_W = k_width(A_BW);
    localparam int KB_W = k_width(B_BW);

    // Operand widths expressed in the shift-amount width (one bit wider
    // than the index so a full-width shift is representable).
    localparam logic [KA_W:0] A_SPAN = A_BW[KA_W:0];
    localparam logic [KB_W:0] B_SPAN = B_BW[KB_W:0];

    // Leading-one detection ahead of S1
    logic [KA_W-1:0] k1_comb;
    logic [KB_W-1:0] k2_comb;
    logic            a_zero_comb;
    logic            b_zero_comb;

    mitchell_lod_pe #(.BW(A_BW)) u_lod_a (
        .operand   (bus.A),
        .k         (k1_comb),
        .zero_flag (a_zero_comb)
    );

    mitchell_lod_pe #(.BW(B_BW)) u_lod_b (
        .operand   (bus.B),
        .k         (k2_comb),
        .zero_flag (b_zero_comb)
    );

    // Stage registers
    logic            s1_valid_reg;
    logic [A_BW-1:0] s1_a_reg;
    logic [B_BW-1:0] s1_b_reg;
    logic [KA_W-1:0] s1_k1_reg;
    logic [KB_W-1:0] s1_k2_reg;
    logic            s1_az_reg;
    logic            s1_bz_reg;

    logic            s2_valid_reg;
    logic [A_BW-1:0] s2_x1_reg;
    logic [B_BW-1:0] s2_x2_reg;
    logic [KA_W-1:0] s2_k1_reg;
    logic [KB_W-1:0] s2_k2_reg;
    logic            s2_az_reg;
    logic            s2_bz_reg;

    // Elastic handshake: a stage advances when it is empty or its
    // successor is taking its contents this cycle. in_ready depends only
    // on state, out_ready and rst, never on in_valid.
    logic s2_load;
    logic s1_load;

    assign s2_load      = !s2_valid_reg || bus.out_ready;
    assign s1_load      = !s1_valid_reg || s2_load;
    assign bus.in_ready = !rst && s1_load;

    // Fraction = operand << (BW - k), truncated. Shifting by the full
    // width for k = 0 clears the value, covering operands 0 and 1.
    logic [KA_W:0]   sh_a;
    logic [KB_W:0]   sh_b;
    logic [A_BW-1:0] x1_next;
    logic [B_BW-1:0] x2_next;

    assign sh_a    = A_SPAN - {1'b0, s1_k1_reg};
    assign sh_b    = B_SPAN - {1'b0, s1_k2_reg};
    assign x1_next = s1_a_reg << sh_a;
    assign x2_next = s1_b_reg << sh_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_k1_reg    <= '0;
            s1_k2_reg    <= '0;
            s1_az_reg    <= 1'b0;
            s1_bz_reg    <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_x1_reg    <= '0;
            s2_x2_reg    <= '0;
            s2_k1_reg    <= '0;
            s2_k2_reg    <= '0;
            s2_az_reg    <= 1'b0;
            s2_bz_reg    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_reg  <= bus.A;
                    s1_b_reg  <= bus.B;
                    s1_k1_reg <= k1_comb;
                    s1_k2_reg <= k2_comb;
                    s1_az_reg <= a_zero_comb;
                    s1_bz_reg <= b_zero_comb;
                end
            end
            // S2 data only changes when a new pair arrives, so the
            // outputs stay put while the consumer stalls.
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_x1_reg <= x1_next;
                    s2_x2_reg <= x2_next;
                    s2_k1_reg <= s1_k1_reg;
                    s2_k2_reg <= s1_k2_reg;
                    s2_az_reg <= s1_az_reg;
                    s2_bz_reg <= s1_bz_reg;
                end
            end
        end
    end

    assign bus.out_valid   = s2_valid_reg;
    assign bus.k_1         = s2_k1_reg;
    assign bus.k_2         = s2_k2_reg;
    assign bus.x_1         = s2_x1_reg;
    assign bus.x_2         = s2_x2_reg;
    assign bus.A_zero_flag = s2_az_reg;
    assign bus.B_zero_flag = s2_bz_reg;

endmodule

// File: tb/tb_mitchell_log_encoder.sv
// Scoreboard bench for mitchell_log_encoder: the driver pushes expected
// encodings into a queue on each accepted pair, a monitor pops and
// compares on each output transfer and checks hold stability under stall.
module tb_mitchell_log_encoder;
    import mitchell_pkg::*;

    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mitchell_log_encoder_if #(.A_BW(BW), .B_BW(BW)) bus ();

    mitchell_log_encoder #(.A_BW(BW), .B_BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        enc_a_t       ea;
        enc_b_t       eb;
        logic [127:0] prod;
        int           acc_cyc;
        bit           check_lat;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  cyc      = 0;
    int  rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    // floor(log2(v)) by repeated halving; 0 for v <= 1
    function automatic int ref_k(input logic [31:0] v);
        int          k = 0;
        logic [31:0] t = v;
        while (t > 1) begin
            t = t / 2;
            k++;
        end
        return k;
    endfunction

    // Fraction (v - 2^k) / 2^k expressed in 32 fractional bits
    function automatic logic [31:0] ref_x(input logic [31:0] v);
        int          k;
        logic [63:0] frac;
        if (v == 0) return 32'd0;
        k    = ref_k(v);
        frac = 64'(v) - (64'd1 << k);
        frac = frac * (64'd1 << (32 - k));
        return frac[31:0];
    endfunction

    // Mitchell product from integers: with S = 2^k2*A + 2^k1*B and
    // P = 2^(k1+k2), result is S-P when f1+f2<1, else 2S-4P.
    function automatic logic [127:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        int           k1;
        int           k2;
        logic [127:0] s;
        logic [127:0] p;
        if (a == 0 || b == 0) return 128'd0;
        k1 = ref_k(a);
        k2 = ref_k(b);
        p  = 128'd1 << (k1 + k2);
        s  = (128'(a) << k2) + (128'(b) << k1);
        if (s >= 3 * p) return 2 * s - 4 * p;
        return s - p;
    endfunction

    // Multiplication unit fed directly from the encoder outputs
    function automatic logic [127:0] mitchell_mul(input logic [4:0] k1, input logic [31:0] x1,
                                                  input logic az, input logic [4:0] k2,
                                                  input logic [31:0] x2, input logic bz);
        logic [127:0] sum;
        int           ksum;
        if (az || bz) return 128'd0;
        ksum = int'(k1) + int'(k2);
        sum  = 128'(x1) + 128'(x2);
        if (sum[32]) return (sum << (ksum + 1)) >> 32;
        return (((128'd1 << 32) + sum) << ksum) >> 32;
    endfunction

    function automatic enc_a_t mk_a(input int k, input logic [31:0] x, input logic z);
        enc_a_t r;
        r.k = k[K_A_W-1:0]; r.x = x; r.zero_flag = z;
        return r;
    endfunction

    function automatic enc_b_t mk_b(input int k, input logic [31:0] x, input logic z);
        enc_b_t r;
        r.k = k[K_B_W-1:0]; r.x = x; r.zero_flag = z;
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2, 3:    return $urandom();
            default: return $urandom() >> $urandom_range(0, 31);
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit directed,
                        input enc_a_t ea_d, input enc_b_t eb_d, input bit lat);
        sb_t e;
        bit  done = 1'b0;
        e.a = a; e.b = b; e.prod = ref_prod(a, b); e.check_lat = lat; e.acc_cyc = 0;
        if (directed) begin
            e.ea = ea_d; e.eb = eb_d;
        end else begin
            e.ea = mk_a(ref_k(a), ref_x(a), a == 0);
            e.eb = mk_b(ref_k(b), ref_x(b), b == 0);
        end
        bus.in_valid = 1'b1; bus.A = a; bus.B = b;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic send_rnd();
        send(rnd_op(), rnd_op(), 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_pending", sb_q.size(), 0);
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        sb_t          e;
        logic         held;
        logic [75:0]  hold_data;
        logic [75:0]  cur_data;
        held = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            cur_data = {bus.k_1, bus.x_1, bus.A_zero_flag, bus.k_2, bus.x_2, bus.B_zero_flag};
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_out_valid", bus.out_valid, 1'b1);
                    check("hold_outputs", cur_data, hold_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    held = 1'b0;
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL stale_output: got pair k_1=%0d x_1=0x%0h, required no output", bus.k_1, bus.x_1);
                    end else begin
                        e = sb_q.pop_front();
                        check("k_1", bus.k_1, e.ea.k);
                        check("x_1", bus.x_1, e.ea.x);
                        check("A_zero_flag", bus.A_zero_flag, e.ea.zero_flag);
                        check("k_2", bus.k_2, e.eb.k);
                        check("x_2", bus.x_2, e.eb.x);
                        check("B_zero_flag", bus.B_zero_flag, e.eb.zero_flag);
                        check("product", mitchell_mul(bus.k_1, bus.x_1, bus.A_zero_flag,
                                                      bus.k_2, bus.x_2, bus.B_zero_flag), e.prod);
                        if (e.check_lat) check("latency", cyc - e.acc_cyc, 2);
                        $display("pair A=0x%08h B=0x%08h -> k_1=%0d x_1=0x%08h zA=%0b k_2=%0d x_2=0x%08h zB=%0b",
                                 e.a, e.b, bus.k_1, bus.x_1, bus.A_zero_flag,
                                 bus.k_2, bus.x_2, bus.B_zero_flag);
                    end
                end else if (bus.out_valid) begin
                    held = 1'b1;
                    hold_data = cur_data;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_outputs", {bus.k_1, bus.x_1, bus.A_zero_flag, bus.k_2, bus.x_2, bus.B_zero_flag}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vectors, back to back, no backpressure
        rdy_mode = 0;
        send(32'd12, 32'hFFFF_FFFF, 1'b1, mk_a(3, 32'h8000_0000, 1'b0), mk_b(31, 32'hFFFF_FFFE, 1'b0), 1'b1);
        send(32'd0, 32'd1, 1'b1, mk_a(0, 32'd0, 1'b1), mk_b(0, 32'd0, 1'b0), 1'b1);
        send(32'h8000_0000, 32'h0001_0000, 1'b1, mk_a(31, 32'd0, 1'b0), mk_b(16, 32'd0, 1'b0), 1'b1);
        wait_drain();

        // Backpressure: 4 pairs while the consumer stalls for ~5 cycles
        @(posedge clk); #1;
        rdy_mode = 2;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rnd();
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", bus.in_ready, 1'b0);
                check("bp_accepted", sb_q.size(), 2);
                check("bp_out_valid", bus.out_valid, 1'b1);
                repeat (2) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Reset with two pairs in flight
        rdy_mode = 2;
        @(posedge clk); #1;
        send_rnd();
        send_rnd();
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_stale", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Random stream with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_rnd();
        end
        rdy_mode = 0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
